param_sequence_detector: RTL and testbench
==========================================

Name: param_sequence_detector

Overview:
- Parametrised successor to the team's fixed-pattern serial sequence detectors.
- Detects a runtime-programmable bit pattern of 1..MAX_LEN bits on a qualified serial input.
- Overlapping or non-overlapping mode is selectable at runtime; matches are counted with a saturating counter.
- Sits on serial-bit streams behind a deserialiser or test stimulus; replaces the per-pattern hard-coded FSM detectors.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- COUNT_W, 16, width of the match counter.
- DEFAULT_PATTERN, 8'b0000_1001, pattern loaded at reset, right-aligned (LSB = last bit).
- DEFAULT_LEN, 4, pattern length loaded at reset.
- DEFAULT_OVERLAP, 1, mode at reset: 1 = overlapping, 0 = non-overlapping.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- cfg_load  in  1  one-cycle strobe; latch cfg_* fields.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit[cfg_len-1] is the first bit received.
- cfg_len  in  LEN_W  pattern length, where LEN_W = clog2(MAX_LEN+1).
- cfg_overlap  in  1  mode to latch.
- count_clr  in  1  synchronous clear of match_count.
- dout  out  1  one-cycle pulse per match.
- match_count  out  COUNT_W  saturating match total.
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout=0, cfg_err=0, match_count=0, history=0, fill=0.
  - Active config = DEFAULT_PATTERN / DEFAULT_LEN / DEFAULT_OVERLAP.
- Reset mid-stream discards all partial progress; the first sample after release starts from empty.
- History: MAX_LEN-bit shift register; on din_valid, history <= {history[MAX_LEN-2:0], din}.
- fill counts valid bits accepted since reset, config load or a non-overlap match; it saturates at MAX_LEN.
- Match condition, evaluated on the incoming sample: fill+1 >= len AND low len bits of {history, din} equal the low len bits of the pattern.
- Latency: dout is registered and goes high the cycle after the din_valid sample that completes the pattern.
  - dout is high for exactly one cycle per match.
  - dout=0 on any cycle with din_valid low.
- Overlapping mode: fill continues after a match; for 1001, the stream 1001001 matches twice.
- Non-overlapping mode: when a match occurs, fill is cleared to 0 on the same edge (history still shifts); the next match needs len fresh bits.
- din_valid low: history, fill and dout hold/deassert; bubbles are transparent to matching.
- cfg_load, when 1 <= cfg_len <= MAX_LEN:
  - Latch pattern, len and overlap; clear history and fill.
  - match_count is kept.
  - A din sample in the same cycle is discarded, and no match is evaluated against either config.
- cfg_load with cfg_len=0 or cfg_len>MAX_LEN:
  - Config is unchanged; cfg_err pulses 1 cycle later.
  - That cycle's din sample is processed normally.
- Pattern bits above len are ignored.
- match_count increments on the same edge that sets dout and saturates at 2^COUNT_W-1.
- count_clr has priority over an increment in the same cycle (result is 0).
- len=1: every valid bit equal to pattern[0] matches. In non-overlap mode, a 1-bit pattern behaves the same as overlap mode.

Decomposition:
- Package seqdet_pkg holds:
  - LEN_W derivation (clog2 function).
  - Default pattern/len/mode constants.
  - Mode encoding localparams (MODE_OVERLAP=1, MODE_NONOVERLAP=0).
- Sub-module seqdet_shift_window contains history shift register, fill counter (with clear/saturate), and masked compare producing a combinational hit.
- Top level contains config registers, validation, dout register, match counter and cfg_err.

Test Plan:
1. Overlap, reset defaults (1001, len 4): din_valid=1, stream 1,0,0,1,0,0,1 -> dout pulses the cycle after samples 4 and 7; match_count=2.
2. Non-overlap: cfg_load pattern 1001, len 4, overlap=0, then the same stream -> dout only after sample 4; match_count increments by 1.
3. Reprogram: cfg_load pattern 110, len 3, overlap=1, with a simultaneous din=1 (discarded); then 1,1,0,1,1,0 with din_valid gaps of 2 idle cycles between bits -> dout after samples 3 and 6 only, never during gaps.
4. Reset mid-operation: default config, feed 1,0,0, pulse rst_n low asynchronously (between edges), release, feed 1 -> no dout; outputs read 0 immediately on assertion.
5. Saturation/clear with COUNT_W=2, pattern 1, len 1: 5 ones -> match_count 1,2,3,3,3; count_clr concurrent with the 6th match -> 0.
6. Invalid config: cfg_load cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; stream 1001 still matches with default config.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Holds the reset-time defaults, the mode encoding and the length-width helper.
package seqdet_pkg;

   localparam logic MODE_OVERLAP    = 1'b1;
   localparam logic MODE_NONOVERLAP = 1'b0;

   localparam logic [31:0] SEQDET_DEFAULT_PATTERN = 32'b0000_1001;
   localparam int          SEQDET_DEFAULT_LEN     = 4;
   localparam logic        SEQDET_DEFAULT_OVERLAP = MODE_OVERLAP;

   // Smallest number of bits that can hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/seqdet_shift_window.sv
// Serial history window: shift register, fill counter and masked pattern compare.
// The hit output is combinational and refers to the sample presented this cycle.
module seqdet_shift_window
   import seqdet_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = clog2(MAX_LEN + 1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               sample,
   input  logic               din,
   input  logic               nonoverlap,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               hit
);

   logic [MAX_LEN-1:0] history;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN:0]   window;
   logic [MAX_LEN-1:0] mask;
   logic               enough;
   logic               equal;

   assign window = {history, din};

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
   end

   // The top window bit is always masked off: at most MAX_LEN bits are compared.
   assign enough = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len};
   assign equal  = ((window ^ {1'b0, pattern}) & {1'b0, mask}) == '0;
   assign hit    = sample & enough & equal;

   // A non-overlapping match restarts the fill count but the history keeps shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         history <= '0;
         fill    <= '0;
      end else if (clear) begin
         history <= '0;
         fill    <= '0;
      end else if (sample) begin
         history <= window[MAX_LEN-1:0];
         if (hit && nonoverlap) begin
            fill <= '0;
         end else if (fill != LEN_W'(MAX_LEN)) begin
            fill <= fill + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter; rejected configuration writes pulse cfg_err.
module param_sequence_detector
   import seqdet_pkg::*;
#(
   parameter int               MAX_LEN         = 8,
   parameter int               COUNT_W         = 16,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(SEQDET_DEFAULT_PATTERN),
   parameter int               DEFAULT_LEN     = SEQDET_DEFAULT_LEN,
   parameter logic             DEFAULT_OVERLAP = SEQDET_DEFAULT_OVERLAP,
   localparam int              LEN_W           = clog2(MAX_LEN + 1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               count_clr,
   output logic               dout,
   output logic [COUNT_W-1:0] match_count,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic               cfg_ok;
   logic               load_ok;
   logic               sample;
   logic               hit;

   assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   assign load_ok = cfg_load & cfg_ok;
   // A sample arriving with an accepted reload belongs to neither configuration.
   assign sample  = din_valid & ~load_ok;

   seqdet_shift_window #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_window (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (load_ok),
      .sample     (sample),
      .din        (din),
      .nonoverlap (overlap_q == MODE_NONOVERLAP),
      .pattern    (pattern_q),
      .len        (len_q),
      .hit        (hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q <= DEFAULT_PATTERN;
         len_q     <= LEN_W'(DEFAULT_LEN);
         overlap_q <= DEFAULT_OVERLAP;
      end else if (load_ok) begin
         pattern_q <= cfg_pattern;
         len_q     <= cfg_len;
         overlap_q <= cfg_overlap;
      end
   end

   // Clearing the counter wins over a match landing in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout        <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         dout    <= hit;
         cfg_err <= cfg_load & ~cfg_ok;
         if (count_clr) begin
            match_count <= '0;
         end else if (hit && (match_count != '1)) begin
            match_count <= match_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Self-checking bench for param_sequence_detector: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_param_sequence_detector;

   localparam int MAX_LEN = 8;
   localparam int COUNT_W = 2;
   localparam int CNT_MAX = (1 << COUNT_W) - 1;

   logic               clk;
   logic               rst_n;
   logic               din;
   logic               din_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [3:0]         cfg_len;
   logic               cfg_overlap;
   logic               count_clr;
   logic               dout;
   logic [COUNT_W-1:0] match_count;
   logic               cfg_err;

   // Reference model: the accepted bits of the current segment, oldest first.
   bit [MAX_LEN-1:0] m_pat;
   int               m_len;
   bit               m_ovl;
   bit               hist[$];
   int               m_count;
   bit               exp_dout;
   bit               exp_err;
   int               checks;
   int               fails;
   int               cyc;

   param_sequence_detector #(
      .MAX_LEN (MAX_LEN),
      .COUNT_W (COUNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .count_clr   (count_clr),
      .dout        (dout),
      .match_count (match_count),
      .cfg_err     (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_pat    = 8'b0000_1001;
      m_len    = 4;
      m_ovl    = 1'b1;
      hist.delete();
      m_count  = 0;
      exp_dout = 1'b0;
      exp_err  = 1'b0;
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, and
   // return 1 time unit after the rising edge so outputs can be sampled.
   task automatic apply_stimulus(input bit d, input bit v, input bit ld,
                                 input logic [MAX_LEN-1:0] p, input int l,
                                 input bit o, input bit clr);
      bit valid_cfg;
      bit hit;
      @(negedge clk);
      din         = d;
      din_valid   = v;
      cfg_load    = ld;
      cfg_pattern = p;
      cfg_len     = 4'(l);
      cfg_overlap = o;
      count_clr   = clr;
      valid_cfg   = ld && (l >= 1) && (l <= MAX_LEN);
      hit         = 1'b0;
      if (valid_cfg) begin
         m_pat = p;
         m_len = l;
         m_ovl = o;
         hist.delete();
      end else if (v) begin
         hist.push_back(d);
         if (hist.size() > MAX_LEN) void'(hist.pop_front());
         if (hist.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) begin
               if (hist[hist.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
            end
         end
         if (hit && !m_ovl) hist.delete();
      end
      exp_dout = hit;
      exp_err  = ld && !valid_cfg;
      if (clr) m_count = 0;
      else if (hit && m_count < CNT_MAX) m_count++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic assert_reset_async();
      #2;
      rst_n     = 1'b0;
      din_valid = 1'b0;
      cfg_load  = 1'b0;
      count_clr = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; din = 0; din_valid = 0; cfg_load = 0; cfg_pattern = '0;
      cfg_len = '0; cfg_overlap = 0; count_clr = 0;
      model_reset();
      @(posedge clk);
      #1;
      checks += 3;
      if (dout !== 1'b0) begin fails++; $display("[TB] FAIL reset_dout: got %b expected 0", dout); end
      if (match_count !== '0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", match_count); end
      if (cfg_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", cfg_err); end
      release_reset();
   endtask

   task automatic test_overlap();
      bit stream [0:6] = '{1, 0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(stream[i], 1, 0, '0, 0, 0, 0);
         checks += 3;
         if (dout !== exp_dout) begin fails++; $display("[TB] FAIL overlap_dout cycle %0d: got %b expected %b", cyc, dout, exp_dout); end
         if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL overlap_count cycle %0d: got %0d expected %0d", cyc, match_count, m_count); end
         if (cfg_err !== exp_err) begin fails++; $display("[TB] FAIL overlap_err cycle %0d: got %b expected %b", cyc, cfg_err, exp_err); end
      end
      checks++;
      if (match_count !== 2'd2) begin fails++; $display("[TB] FAIL overlap_total: got %0d expected 2", match_count); end
   endtask

   task automatic test_nonoverlap();
      bit stream [0:6] = '{1, 0, 0, 1, 0, 0, 1};
      apply_stimulus(0, 0, 1, 8'b0000_1001, 4, 0, 1);
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(stream[i], 1, 0, '0, 0, 0, 0);
         checks += 3;
         if (dout !== exp_dout) begin fails++; $display("[TB] FAIL nonoverlap_dout cycle %0d: got %b expected %b", cyc, dout, exp_dout); end
         if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL nonoverlap_count cycle %0d: got %0d expected %0d", cyc, match_count, m_count); end
         if (cfg_err !== exp_err) begin fails++; $display("[TB] FAIL nonoverlap_err cycle %0d: got %b expected %b", cyc, cfg_err, exp_err); end
      end
      checks++;
      if (match_count !== 2'd1) begin fails++; $display("[TB] FAIL nonoverlap_total: got %0d expected 1", match_count); end
   endtask

   task automatic test_reprogram_gaps();
      bit stream [0:5] = '{1, 1, 0, 1, 1, 0};
      apply_stimulus(1, 1, 1, 8'b0000_0110, 3, 1, 1);
      for (int i = 0; i < 6; i++) begin
         for (int g = 0; g < 3; g++) begin
            if (g == 0) apply_stimulus(stream[i], 1, 0, '0, 0, 0, 0);
            else        apply_stimulus($urandom_range(0, 1), 0, 0, '0, 0, 0, 0);
            checks += 2;
            if (dout !== exp_dout) begin fails++; $display("[TB] FAIL gaps_dout cycle %0d: got %b expected %b", cyc, dout, exp_dout); end
            if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL gaps_count cycle %0d: got %0d expected %0d", cyc, match_count, m_count); end
         end
      end
      checks++;
      if (match_count !== 2'd2) begin fails++; $display("[TB] FAIL gaps_total: got %0d expected 2", match_count); end
   endtask

   task automatic test_reset_mid();
      bit pre [0:3]  = '{1, 0, 0, 1};
      bit post [0:3] = '{1, 0, 0, 1};
      assert_reset_async();
      release_reset();
      for (int i = 0; i < 4; i++) apply_stimulus(pre[i], 1, 0, '0, 0, 0, 0);
      checks += 2;
      if (dout !== 1'b1) begin fails++; $display("[TB] FAIL resetmid_predout: got %b expected 1", dout); end
      if (match_count !== 2'd1) begin fails++; $display("[TB] FAIL resetmid_precount: got %0d expected 1", match_count); end
      apply_stimulus(0, 1, 0, '0, 0, 0, 0);
      apply_stimulus(0, 1, 0, '0, 0, 0, 0);
      apply_stimulus(1, 1, 0, '0, 0, 0, 0);
      apply_stimulus(0, 1, 0, '0, 0, 0, 0);
      apply_stimulus(0, 1, 0, '0, 0, 0, 0);
      assert_reset_async();
      checks += 2;
      if (dout !== 1'b0) begin fails++; $display("[TB] FAIL resetmid_dout_async: got %b expected 0", dout); end
      if (match_count !== '0) begin fails++; $display("[TB] FAIL resetmid_count_async: got %0d expected 0", match_count); end
      release_reset();
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(post[i], 1, 0, '0, 0, 0, 0);
         checks += 2;
         if (dout !== exp_dout) begin fails++; $display("[TB] FAIL resetmid_dout cycle %0d: got %b expected %b", cyc, dout, exp_dout); end
         if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL resetmid_count cycle %0d: got %0d expected %0d", cyc, match_count, m_count); end
         if (i == 0) begin
            checks++;
            if (dout !== 1'b0) begin fails++; $display("[TB] FAIL resetmid_stale: got %b expected 0", dout); end
         end
      end
   endtask

   task automatic test_saturation();
      logic [COUNT_W-1:0] want [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      apply_stimulus(0, 0, 1, 8'b1111_1101, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1, 1, 0, '0, 0, 0, 0);
         checks += 3;
         if (dout !== 1'b1) begin fails++; $display("[TB] FAIL sat_dout step %0d: got %b expected 1", i, dout); end
         if (match_count !== want[i]) begin fails++; $display("[TB] FAIL sat_count step %0d: got %0d expected %0d", i, match_count, want[i]); end
         if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL sat_model step %0d: got %0d expected %0d", i, match_count, m_count); end
      end
      apply_stimulus(1, 1, 0, '0, 0, 0, 1);
      checks += 2;
      if (dout !== 1'b1) begin fails++; $display("[TB] FAIL clr_dout: got %b expected 1", dout); end
      if (match_count !== '0) begin fails++; $display("[TB] FAIL clr_count: got %0d expected 0", match_count); end
   endtask

   task automatic test_invalid_cfg();
      assert_reset_async();
      release_reset();
      apply_stimulus(1, 1, 1, 8'hFF, 0, 0, 0);
      checks += 2;
      if (cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL badcfg_len0_err: got %b expected 1", cfg_err); end
      if (dout !== 1'b0) begin fails++; $display("[TB] FAIL badcfg_len0_dout: got %b expected 0", dout); end
      apply_stimulus(0, 1, 1, 8'hFF, MAX_LEN + 1, 0, 0);
      checks++;
      if (cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL badcfg_lenmax_err: got %b expected 1", cfg_err); end
      apply_stimulus(0, 1, 0, '0, 0, 0, 0);
      checks++;
      if (cfg_err !== 1'b0) begin fails++; $display("[TB] FAIL badcfg_err_pulse: got %b expected 0", cfg_err); end
      apply_stimulus(1, 1, 0, '0, 0, 0, 0);
      checks += 3;
      if (dout !== 1'b1) begin fails++; $display("[TB] FAIL badcfg_match: got %b expected 1", dout); end
      if (dout !== exp_dout) begin fails++; $display("[TB] FAIL badcfg_model: got %b expected %b", dout, exp_dout); end
      if (match_count !== 2'd1) begin fails++; $display("[TB] FAIL badcfg_count: got %0d expected 1", match_count); end
   endtask

   task automatic test_random();
      bit d, v, ld, o, clr;
      int l;
      logic [MAX_LEN-1:0] p;
      for (int n = 0; n < 600; n++) begin
         d   = 1'($urandom_range(0, 1));
         v   = ($urandom_range(0, 3) != 0);
         ld  = ($urandom_range(0, 24) == 0);
         l   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
         p   = MAX_LEN'($urandom);
         o   = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 29) == 0);
         apply_stimulus(d, v, ld, p, l, o, clr);
         checks += 3;
         if (dout !== exp_dout) begin fails++; $display("[TB] FAIL random_dout cycle %0d: got %b expected %b", cyc, dout, exp_dout); end
         if (match_count !== COUNT_W'(m_count)) begin fails++; $display("[TB] FAIL random_count cycle %0d: got %0d expected %0d", cyc, match_count, m_count); end
         if (cfg_err !== exp_err) begin fails++; $display("[TB] FAIL random_err cycle %0d: got %b expected %b", cyc, cfg_err, exp_err); end
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      cyc    = 0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_reprogram_gaps();
      test_reset_mid();
      test_saturation();
      test_invalid_cfg();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
